// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: signal bundle between the keypad scanner and its users.
//   row       : keypad row lines into the scanner (active-low, pulled up)
//   col       : column strobes out of the scanner (active-low, one-hot-low)
//   key       : code of the last accepted key, {row_idx, col_idx}
//   key_valid : one-cycle pulse when a new key is accepted
//   key_held  : high while the accepted key remains pressed
// master = scanner side, slave = keypad/datapath side.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row,
    output col,
    output key,
    output key_valid,
    output key_held
  );

  modport slave (
    output row,
    input  col,
    input  key,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: strobes the four columns of a 4x4 matrix keypad, reads the
// rows back through a 2-flop synchronizer, builds one 16-bit snapshot per
// sweep and debounces the per-sweep key candidate into single-pulse events.
// Ports:
//   clock : system clock
//   reset : synchronous, active-low reset
//   kp    : keypad_scanner_if.master (row in; col, key, key_valid, key_held out)
// Parameters:
//   SCAN_DIV : cycles each column is driven (>= 4)
//   DEBOUNCE : identical consecutive sweeps needed to accept a press/release (>= 1)
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic             clock,
  input  logic             reset,
  keypad_scanner_if.master kp
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE);
  // Candidate encoding: {none, code}; NONE covers both "no key" and ghosting.
  localparam logic [4:0] CAND_NONE = 5'b1_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       row_s1;
  logic [3:0]       row_s2;
  logic [CNT_W-1:0] dwell_cnt;
  logic [1:0]       col_idx;
  logic [15:0]      snap;
  logic [4:0]       prev_cand;
  logic [DB_W-1:0]  sweep_cnt;

  logic [3:0]       col_q;
  logic [3:0]       key_q;
  logic             key_valid_q;
  logic             key_held_q;

  logic [1:0]       col_nxt_c;
  logic [15:0]      snap_c;
  logic             any_c;
  logic             multi_c;
  logic [3:0]       code_c;
  logic [4:0]       cand_c;
  logic [DB_W-1:0]  sweep_nxt_c;
  logic             done_c;

  assign kp.col       = col_q;
  assign kp.key       = key_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

  assign col_nxt_c = col_idx + 2'd1;

  // Snapshot as it will look once the current column's sample is folded in,
  // so the column-3 sample can be evaluated in the same cycle it is taken.
  always_comb begin
    snap_c = snap;
    snap_c[{col_idx, 2'b00} +: 4] = row_s2;
  end

  // Classify the sweep: exactly one low bit gives a key code, else NONE.
  // Snapshot bit 4c+r maps to code {r, c}.
  always_comb begin
    any_c   = 1'b0;
    multi_c = 1'b0;
    code_c  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (!snap_c[i]) begin
        multi_c = multi_c | any_c;
        any_c   = 1'b1;
        code_c  = {2'(i % 4), 2'(i / 4)};
      end
    end
    cand_c = (any_c && !multi_c) ? {1'b0, code_c} : CAND_NONE;
  end

  // Consecutive-identical-sweep count, saturating at DEBOUNCE.
  always_comb begin
    if (cand_c == prev_cand) begin
      sweep_nxt_c = (sweep_cnt == DB_MAX) ? sweep_cnt : sweep_cnt + DB_W'(1);
    end else begin
      sweep_nxt_c = DB_W'(1);
    end
    done_c = (sweep_nxt_c == DB_MAX);
  end

  // Scan timing, sampling, debounce counters and key FSM.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      row_s1      <= 4'hF;
      row_s2      <= 4'hF;
      dwell_cnt   <= '0;
      col_idx     <= 2'd0;
      snap        <= 16'hFFFF;
      prev_cand   <= CAND_NONE;
      sweep_cnt   <= '0;
      col_q       <= 4'b1110;
      key_q       <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      row_s1      <= kp.row;
      row_s2      <= row_s1;
      key_valid_q <= 1'b0;

      if (dwell_cnt == CNT_MAX) begin
        dwell_cnt <= '0;
        col_idx   <= col_nxt_c;
        col_q     <= ~(4'b0001 << col_nxt_c);
        snap      <= snap_c;

        // End of sweep: update debounce history and step the FSM.
        if (col_idx == 2'd3) begin
          prev_cand <= cand_c;
          sweep_cnt <= sweep_nxt_c;

          case (state)
            IDLE: begin
              if (!cand_c[4] && done_c) begin
                key_q       <= cand_c[3:0];
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                state       <= HELD;
              end
            end

            HELD, RELEASE: begin
              if (cand_c == {1'b0, key_q}) begin
                state <= HELD;
              end else if (done_c) begin
                key_held_q <= 1'b0;
                state      <= IDLE;
                // A different stable key is treated as a release; clearing the
                // count makes it debounce afresh before it can be accepted.
                if (!cand_c[4]) begin
                  sweep_cnt <= '0;
                end
              end else begin
                state <= RELEASE;
              end
            end

            default: begin
              state <= IDLE;
            end
          endcase
        end
      end else begin
        dwell_cnt <= dwell_cnt + CNT_W'(1);
      end
    end
  end

endmodule
